// File: rtl/minmax_sort_pkg.sv
// Shared types and constants for the min/max bubble-sort controller.
package minmax_sort_pkg;

  localparam int DEF_W = 8;
  localparam int DEF_N = 4;
  localparam int IDX_W = $clog2(DEF_N);
  localparam int CNT_W = IDX_W;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SORT,
    ST_DRAIN
  } state_t;

  // Index width for an n-entry buffer; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/minmax_sort_ctrl_cmp_xchg.sv
// Combinational compare-exchange: lo=min(a,b), hi=max(a,b), swap when a>b.
module cmp_xchg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swap
);

  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/minmax_sort_ctrl.sv
// Loads N words, bubble-sorts them through one shared compare-exchange, drains ascending.
// Optional: define MINMAX_SORT_EARLY_EXIT_EN to end SORT after a pass with no swaps.
//
// state    | meaning
// ST_LOAD  | accepting input words into mem
// ST_SORT  | one compare-exchange per cycle, bubble order
// ST_DRAIN | presenting mem[rd_idx] on the output stream
module minmax_sort_ctrl
  import minmax_sort_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy
);

  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

  state_t        state, state_nxt;
  logic [W-1:0]  mem [N];
  logic [IW-1:0] wr_idx, rd_idx, pass_idx, pair_idx, pair_hi;
  logic [W-1:0]  cx_lo, cx_hi;
  logic          cx_swap;
  logic          in_fire, out_fire, last_pair, sort_done;

  assign pair_hi   = pair_idx + 1'b1;
  assign in_fire   = in_valid && (state == ST_LOAD);
  assign out_fire  = out_ready && (state == ST_DRAIN);
  assign last_pair = (pair_idx == (LAST_PASS - pass_idx));

  cmp_xchg #(.W(W)) u_cx (
    .a    (mem[pair_idx]),
    .b    (mem[pair_hi]),
    .lo   (cx_lo),
    .hi   (cx_hi),
    .swap (cx_swap)
  );

`ifdef MINMAX_SORT_EARLY_EXIT_EN
  logic swap_seen;

  // The current compare counts toward its own pass.
  assign sort_done = last_pair && ((pass_idx == LAST_PASS) || !(swap_seen || cx_swap));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_seen <= 1'b0;
    end else if (state == ST_SORT) begin
      swap_seen <= last_pair ? 1'b0 : (swap_seen || cx_swap);
    end else begin
      swap_seen <= 1'b0;
    end
  end
`else
  assign sort_done = last_pair && (pass_idx == LAST_PASS);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      ST_LOAD: begin
        in_ready = !rst;
        if (in_fire && (wr_idx == LAST_IDX)) state_nxt = ST_SORT;
      end
      ST_SORT: begin
        busy = 1'b1;
        if (sort_done) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_fire && (rd_idx == LAST_IDX)) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  assign out_data = (state == ST_DRAIN) ? mem[rd_idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) mem[k] <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      pass_idx <= '0;
      pair_idx <= '0;
    end else begin
      if (in_fire) begin
        mem[wr_idx] <= in_data;
        wr_idx      <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
      end
      if (state == ST_SORT) begin
        // Equal or ordered pairs leave mem untouched.
        if (cx_swap) begin
          mem[pair_idx] <= cx_lo;
          mem[pair_hi]  <= cx_hi;
        end
        if (last_pair) begin
          pair_idx <= '0;
          pass_idx <= sort_done ? '0 : pass_idx + 1'b1;
        end else begin
          pair_idx <= pair_hi;
        end
      end
      if (out_fire) begin
        rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_minmax_sort_ctrl.sv
// Directed, table-driven bench for minmax_sort_ctrl (W=8, N=4).
module tb_minmax_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy;

  int checks = 0;
  int errors = 0;

  minmax_sort_ctrl #(.W(8), .N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

`ifdef MINMAX_SORT_EARLY_EXIT_EN
  localparam int SORTED_LEN = 3;
  localparam int ONE_SWAP_LEN = 5;
`else
  localparam int SORTED_LEN = 6;
  localparam int ONE_SWAP_LEN = 6;
`endif

  typedef struct {
    logic [3:0][7:0] din;
    logic [3:0][7:0] dexp;
    int              sort_len;
    int              gap;
    int              bp_at;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] a0, a1, a2, a3,
                         input logic [7:0] e0, e1, e2, e3,
                         input int slen, input int gap, input int bp_at);
    vecs[i].din[0] = a0; vecs[i].din[1] = a1; vecs[i].din[2] = a2; vecs[i].din[3] = a3;
    vecs[i].dexp[0] = e0; vecs[i].dexp[1] = e1; vecs[i].dexp[2] = e2; vecs[i].dexp[3] = e3;
    vecs[i].sort_len = slen;
    vecs[i].gap = gap;
    vecs[i].bp_at = bp_at;
  endtask

  task automatic feed_words(input logic [3:0][7:0] din, input int gap);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) check("load_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = din[k];
      if (k < 3) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          check("gap_not_busy", {31'd0, busy}, 32'd0);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  sc;
    int  t;
    logic bad;
    feed_words(v.din, v.gap);
    sc  = 0;
    bad = 1'b0;
    while (busy && !out_valid && sc < 100) begin
      sc++;
      if (in_ready || out_valid) bad = 1'b1;
      @(negedge clk);
    end
    check("sort_len", sc, v.sort_len);
    check("sort_idle_ports", {31'd0, bad}, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("drain_valid", {31'd0, out_valid}, 32'd1);
      check("drain_data", {24'd0, out_data}, {24'd0, v.dexp[k]});
      check("drain_in_ready", {31'd0, in_ready}, 32'd0);
      if (k == v.bp_at) begin
        out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          @(negedge clk);
          check("bp_hold_data", {24'd0, out_data}, {24'd0, v.dexp[k]});
          check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    set_vec(0, 8'd3,   8'd1, 8'd2,   8'd0,  8'd0, 8'd1, 8'd2,   8'd3,   6,            0, -1);
    set_vec(1, 8'd0,   8'd1, 8'd2,   8'd3,  8'd0, 8'd1, 8'd2,   8'd3,   SORTED_LEN,   0, -1);
    set_vec(2, 8'd5,   8'd5, 8'd2,   8'd5,  8'd2, 8'd5, 8'd5,   8'd5,   6,            0, -1);
    set_vec(3, 8'd255, 8'd0, 8'd255, 8'd0,  8'd0, 8'd0, 8'd255, 8'd255, 6,            0, -1);
    set_vec(4, 8'd1,   8'd0, 8'd2,   8'd3,  8'd0, 8'd1, 8'd2,   8'd3,   ONE_SWAP_LEN, 0, -1);
    set_vec(5, 8'd4,   8'd3, 8'd2,   8'd1,  8'd1, 8'd2, 8'd3,   8'd4,   6,            0,  2);
    set_vec(6, 8'd2,   8'd0, 8'd3,   8'd1,  8'd0, 8'd1, 8'd2,   8'd3,   6,            2, -1);
    set_vec(7, 8'd9,   8'd8, 8'd7,   8'd6,  8'd6, 8'd7, 8'd8,   8'd9,   6,            0, -1);

    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset in the middle of sorting a batch, then a fresh batch.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd7 - 8'(2 * k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_sort_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rel_out_valid", {31'd0, out_valid}, 32'd0);
    run_vec(vecs[7]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
